memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Shares the single main-memory request/response port between the instruction cache
//  and data cache miss paths. It sits between both caches and main memory.
//  It latches single-cycle miss pulses from each cache and grants one request at a time.
//  Ties are broken round-robin. Each response is steered back to the cache that owns the
//  outstanding request.
// PARAMETERS
//  ADDR_WIDTH  32   request address width (memory_request_t.addr)
//  LINE_WIDTH  128  cache line width carried on req data / rsp data
// PORTS
//  clock           in   1           single clock, all state on rising edge
//  reset           in   1           synchronous, active-high
//  ic_req_valid    in   1           icache miss pulse (1 cycle)
//  ic_req_info     in   mem_req_t   icache request {addr,is_store,data}
//  ic_rsp_valid    out  1           line returned to icache
//  ic_rsp_data     out  LINE_WIDTH  returned line
//  dc_req_valid    in   1           dcache miss/writeback pulse (1 cycle)
//  dc_req_info     in   mem_req_t   dcache request
//  dc_rsp_valid    out  1           response (line or store ack) to dcache
//  dc_rsp_data     out  LINE_WIDTH  returned line
//  mm_req_valid    out  1           request pulse to main memory (1 cycle)
//  mm_req_info     out  mem_req_t   granted request
//  mm_rsp_valid    in   1           main-memory response pulse
//  mm_rsp_data     in   LINE_WIDTH  main-memory line
//  arb_busy        out  1           high while a memory transaction is outstanding
// BEHAVIOUR
//  Reset: FSM=IDLE, ic_pend=dc_pend=0, last_grant=DC, and mm_req_valid, ic/dc_rsp_valid,
//  arb_busy are all 0. All *_data/info outputs are 0. Reset mid-transaction drops
//  everything; an mm_rsp_valid arriving afterwards in IDLE is ignored.
//  Latching: a *_req_valid sets that requester's pend flag and captures its info at the
//  clock edge. This holds in any state.
//  Re-request while the requester's own pend is already set is a protocol violation:
//  ignore it, keep the old info, and fire a simulation assertion.
//  FSM IDLE: arbitration looks at the registered pend flags only, so there is no
//  same-cycle bypass.
//   - If only one pend flag is set, grant it.
//   - If both are set, grant the requester that is not last_grant.
//   - On grant: mm_req_valid=1 for exactly one cycle (registered, so it is high the cycle
//     after the pend flag is seen), mm_req_info = latched info, owner = granted,
//     last_grant = granted, next state = WAIT_RSP.
//   - Minimum latency from a req pulse at cycle N to mm_req_valid is cycle N+2.
//  FSM WAIT_RSP: arb_busy=1 and mm_req_valid=0.
//   - On mm_rsp_valid, drive owner's rsp_valid=1 and rsp_data=mm_rsp_data
//     combinationally in the same cycle.
//   - The other requester's rsp_valid stays 0.
//   - At that edge, clear owner's pend and go to IDLE.
//  Same-cycle cases:
//   - Response and a new req from the owner in the same cycle: the clear loses, so pend
//     stays 1 with the new info.
//   - Response and a new req from the non-owner in the same cycle: latch it normally.
//   - mm_rsp_valid in IDLE: ignored; no rsp_valid is raised.
//  Back-to-back: after a response, the next grant is issued from IDLE. This gives one
//  dead cycle between the response and the next mm_req_valid.
//  Fairness: with both requesters continuously pending, grants alternate IC,DC,IC,DC.
//  After reset the first tie goes to IC.
//  Store requests (is_store=1) are granted identically; the memory's ack is returned as
//  dc_rsp_valid.
// TESTING
//  1. Lone icache miss: ic_req_valid at c0, addr=0x1000 -> mm_req_valid at c2 with
//     addr 0x1000, is_store=0. mm_rsp at c12 with data 0xAA.. -> ic_rsp_valid at c12
//     with data 0xAA.., dc_rsp_valid=0.
//  2. Simultaneous ic (0x1000) and dc (0x2000) pulses at c0 -> IC granted first. After
//     its response, one dead cycle, then DC granted with 0x2000.
//     Repeating this tie case shows the alternation IC,DC,IC,DC.
//  3. DC store (is_store=1, data 0x55..) pulse while an IC transaction is in flight ->
//     latched, then issued exactly 2 cycles after the IC response with info unchanged.
//  4. Reset asserted mid-WAIT_RSP -> outputs 0 the next cycle. A later mm_rsp_valid
//     produces no ic/dc rsp_valid. A new ic request afterwards is served normally.
//  5. Owner issues a new request in the same cycle as its response -> pend is retained
//     and the new address is granted on the following IDLE cycle.
//  6. Spurious mm_rsp_valid in IDLE -> no rsp_valid and no state change. Duplicate
//     ic_req_valid while pending -> assertion fires and the original addr is issued.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Request/response bundle shared by the icache, dcache and main-memory sides of the arbiter.
// The requester drives the master modport and the responder drives the slave modport.
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
);
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_is_store;
    logic [LINE_WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic [LINE_WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_addr, req_is_store, req_data,
        input  rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_is_store, req_data,
        output rsp_valid, rsp_data
    );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one main-memory port between the icache and dcache miss paths.
// Miss pulses are latched, granted one at a time round-robin, and responses are steered back.
module memory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic              i_clock,
    input  logic              i_reset,
    memory_arbiter_if.slave   ic,
    memory_arbiter_if.slave   dc,
    memory_arbiter_if.master  mm,
    output logic              o_arb_busy
);
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  is_store;
        logic [LINE_WIDTH-1:0] data;
    } mem_req_t;

    typedef enum logic { IDLE, WAIT_RSP } state_t;
    typedef enum logic { REQ_IC, REQ_DC } requester_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_ic_pend;
    logic       r_dc_pend;
    mem_req_t   r_ic_info;
    mem_req_t   r_dc_info;
    requester_t r_owner;
    requester_t r_last_grant;
    logic       r_mm_req_valid;
    mem_req_t   r_mm_req_info;

    logic       w_rsp_hit;
    logic       w_ic_done;
    logic       w_dc_done;
    logic       w_ic_take;
    logic       w_dc_take;
    logic       w_grant_valid;
    requester_t w_grant;

    assign w_rsp_hit = (r_state == WAIT_RSP) && mm.rsp_valid;
    assign w_ic_done = w_rsp_hit && (r_owner == REQ_IC);
    assign w_dc_done = w_rsp_hit && (r_owner == REQ_DC);

    // A new pulse from the owner in its response cycle wins over the pend clear.
    assign w_ic_take = ic.req_valid && (!r_ic_pend || w_ic_done);
    assign w_dc_take = dc.req_valid && (!r_dc_pend || w_dc_done);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_state_next  = r_state;
        w_grant_valid = 1'b0;
        w_grant       = r_last_grant;
        case (r_state)
            IDLE: begin
                if (r_ic_pend && r_dc_pend) begin
                    w_grant_valid = 1'b1;
                    w_grant       = (r_last_grant == REQ_IC) ? REQ_DC : REQ_IC;
                end else if (r_ic_pend) begin
                    w_grant_valid = 1'b1;
                    w_grant       = REQ_IC;
                end else if (r_dc_pend) begin
                    w_grant_valid = 1'b1;
                    w_grant       = REQ_DC;
                end
                if (w_grant_valid) begin
                    w_state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mm.rsp_valid) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (i_reset) begin
            r_state        <= IDLE;
            r_ic_pend      <= 1'b0;
            r_dc_pend      <= 1'b0;
            r_ic_info      <= '0;
            r_dc_info      <= '0;
            r_owner        <= REQ_IC;
            r_last_grant   <= REQ_DC;
            r_mm_req_valid <= 1'b0;
            r_mm_req_info  <= '0;
        end else begin
            r_state        <= w_state_next;
            r_mm_req_valid <= w_grant_valid;
            if (w_grant_valid) begin
                r_mm_req_info <= (w_grant == REQ_IC) ? r_ic_info : r_dc_info;
                r_owner       <= w_grant;
                r_last_grant  <= w_grant;
            end

            if (w_ic_take) begin
                r_ic_pend <= 1'b1;
                r_ic_info <= '{addr: ic.req_addr, is_store: ic.req_is_store, data: ic.req_data};
            end else if (w_ic_done) begin
                r_ic_pend <= 1'b0;
            end

            if (w_dc_take) begin
                r_dc_pend <= 1'b1;
                r_dc_info <= '{addr: dc.req_addr, is_store: dc.req_is_store, data: dc.req_data};
            end else if (w_dc_done) begin
                r_dc_pend <= 1'b0;
            end
        end
    end

    // A re-request while still pending is a requester bug; it is dropped and flagged.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            assert (!(ic.req_valid && r_ic_pend && !w_ic_done))
                else $warning("memory_arbiter: icache re-request while pending ignored");
            assert (!(dc.req_valid && r_dc_pend && !w_dc_done))
                else $warning("memory_arbiter: dcache re-request while pending ignored");
        end
    end

    assign mm.req_valid    = r_mm_req_valid;
    assign mm.req_addr     = r_mm_req_info.addr;
    assign mm.req_is_store = r_mm_req_info.is_store;
    assign mm.req_data     = r_mm_req_info.data;

    assign ic.rsp_valid = w_ic_done;
    assign ic.rsp_data  = w_ic_done ? mm.rsp_data : '0;
    assign dc.rsp_valid = w_dc_done;
    assign dc.rsp_data  = w_dc_done ? mm.rsp_data : '0;

    assign o_arb_busy = (r_state == WAIT_RSP);
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: each cycle drives pulses just after the edge
// and checks outputs mid-cycle against hand-computed values.
module tb_memory_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;

    localparam logic [LW-1:0] D_AA = {16{8'hAA}};
    localparam logic [LW-1:0] D_BB = {16{8'hBB}};
    localparam logic [LW-1:0] D_CC = {16{8'hCC}};
    localparam logic [LW-1:0] D_DD = {16{8'hDD}};
    localparam logic [LW-1:0] D_EE = {16{8'hEE}};
    localparam logic [LW-1:0] D_55 = {16{8'h55}};
    localparam logic [LW-1:0] D_11 = {16{8'h11}};
    localparam logic [LW-1:0] D_22 = {16{8'h22}};
    localparam logic [LW-1:0] D_33 = {16{8'h33}};
    localparam logic [LW-1:0] D_44 = {16{8'h44}};
    localparam logic [LW-1:0] D_66 = {16{8'h66}};
    localparam logic [LW-1:0] D_77 = {16{8'h77}};

    logic clk;
    logic rst;
    logic arb_busy;
    int   tests;
    int   fails;

    memory_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) ic_bus ();
    memory_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dc_bus ();
    memory_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) mm_bus ();

    memory_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .ic         (ic_bus),
        .dc         (dc_bus),
        .mm         (mm_bus),
        .o_arb_busy (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        tests++;
        assert (obs === exp)
            else begin
                fails++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        ic_bus.req_valid = 1'b0;
        dc_bus.req_valid = 1'b0;
        mm_bus.rsp_valid = 1'b0;
        mm_bus.rsp_data  = '0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic ic_req(input logic [AW-1:0] addr);
        ic_bus.req_valid    = 1'b1;
        ic_bus.req_addr     = addr;
        ic_bus.req_is_store = 1'b0;
        ic_bus.req_data     = '0;
    endtask

    task automatic dc_req(input logic [AW-1:0] addr, input logic st, input logic [LW-1:0] data);
        dc_bus.req_valid    = 1'b1;
        dc_bus.req_addr     = addr;
        dc_bus.req_is_store = st;
        dc_bus.req_data     = data;
    endtask

    task automatic rsp(input logic [LW-1:0] data);
        mm_bus.rsp_valid = 1'b1;
        mm_bus.rsp_data  = data;
    endtask

    task automatic chk_mm(input string tag, input logic v, input logic [AW-1:0] a,
                          input logic st, input logic [LW-1:0] d);
        check({tag, "_mm_valid"}, LW'(mm_bus.req_valid), LW'(v));
        if (v) begin
            check({tag, "_mm_addr"}, LW'(mm_bus.req_addr), LW'(a));
            check({tag, "_mm_store"}, LW'(mm_bus.req_is_store), LW'(st));
            check({tag, "_mm_data"}, mm_bus.req_data, d);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic icv, input logic dcv, input logic [LW-1:0] d);
        check({tag, "_ic_rsp_valid"}, LW'(ic_bus.rsp_valid), LW'(icv));
        check({tag, "_dc_rsp_valid"}, LW'(dc_bus.rsp_valid), LW'(dcv));
        if (icv) check({tag, "_ic_rsp_data"}, ic_bus.rsp_data, d);
        if (dcv) check({tag, "_dc_rsp_data"}, dc_bus.rsp_data, d);
    endtask

    task automatic chk_busy(input string tag, input logic b);
        check({tag, "_busy"}, LW'(arb_busy), LW'(b));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        ic_bus.req_valid = 1'b0; ic_bus.req_addr = '0; ic_bus.req_is_store = 1'b0; ic_bus.req_data = '0;
        dc_bus.req_valid = 1'b0; dc_bus.req_addr = '0; dc_bus.req_is_store = 1'b0; dc_bus.req_data = '0;
        mm_bus.rsp_valid = 1'b0; mm_bus.rsp_data = '0;

        // Reset state
        cyc(); cyc(); settle();
        check("rst_mm_valid", LW'(mm_bus.req_valid), '0);
        check("rst_mm_addr", LW'(mm_bus.req_addr), '0);
        check("rst_mm_store", LW'(mm_bus.req_is_store), '0);
        check("rst_mm_data", mm_bus.req_data, '0);
        check("rst_ic_rsp_data", ic_bus.rsp_data, '0);
        check("rst_dc_rsp_data", dc_bus.rsp_data, '0);
        chk_rsp("rst", 1'b0, 1'b0, '0);
        chk_busy("rst", 1'b0);
        rst = 1'b0;

        // Simultaneous pulses: first tie after reset goes to IC, then DC
        cyc(); ic_req(32'h1000); dc_req(32'h2000, 1'b0, '0); settle();
        chk_mm("t2_c0", 1'b0, '0, 1'b0, '0);
        cyc(); settle();
        chk_mm("t2_c1", 1'b0, '0, 1'b0, '0);
        chk_busy("t2_c1", 1'b0);
        cyc(); settle();
        chk_mm("t2_ic_grant", 1'b1, 32'h1000, 1'b0, '0);
        chk_busy("t2_c2", 1'b1);
        cyc(); settle();
        chk_mm("t2_c3", 1'b0, '0, 1'b0, '0);
        cyc(); rsp(D_AA); settle();
        chk_rsp("t2_ic_rsp", 1'b1, 1'b0, D_AA);
        cyc(); settle();
        chk_mm("t2_dead", 1'b0, '0, 1'b0, '0);
        chk_busy("t2_dead", 1'b0);
        cyc(); settle();
        chk_mm("t2_dc_grant", 1'b1, 32'h2000, 1'b0, '0);
        cyc(); rsp(D_BB); settle();
        chk_rsp("t2_dc_rsp", 1'b0, 1'b1, D_BB);

        // Second tie continues the alternation IC, DC
        cyc(); ic_req(32'h3000); dc_req(32'h4000, 1'b0, '0);
        cyc();
        cyc(); settle();
        chk_mm("t2b_ic_grant", 1'b1, 32'h3000, 1'b0, '0);
        cyc(); rsp(D_CC); settle();
        chk_rsp("t2b_ic_rsp", 1'b1, 1'b0, D_CC);
        cyc();
        cyc(); settle();
        chk_mm("t2b_dc_grant", 1'b1, 32'h4000, 1'b0, '0);
        cyc(); rsp(D_DD); settle();
        chk_rsp("t2b_dc_rsp", 1'b0, 1'b1, D_DD);
        cyc(); settle();
        chk_busy("t2b_end", 1'b0);

        // Lone icache miss: grant at c2, response at c12
        cyc(); ic_req(32'h1000); settle();
        chk_mm("t1_c0", 1'b0, '0, 1'b0, '0);
        cyc(); settle();
        chk_mm("t1_c1", 1'b0, '0, 1'b0, '0);
        cyc(); settle();
        chk_mm("t1_grant", 1'b1, 32'h1000, 1'b0, '0);
        chk_busy("t1_c2", 1'b1);
        for (int i = 3; i < 12; i++) begin
            cyc(); settle();
            check("t1_wait_mm_valid", LW'(mm_bus.req_valid), '0);
            check("t1_wait_ic_rsp_valid", LW'(ic_bus.rsp_valid), '0);
            chk_busy("t1_wait", 1'b1);
        end
        cyc(); rsp(D_AA); settle();
        chk_rsp("t1_rsp", 1'b1, 1'b0, D_AA);
        cyc(); settle();
        chk_busy("t1_c13", 1'b0);

        // DC store latched during an IC transaction, issued 2 cycles after the IC response
        cyc(); ic_req(32'h5000);
        cyc();
        cyc(); settle();
        chk_mm("t3_ic_grant", 1'b1, 32'h5000, 1'b0, '0);
        cyc(); dc_req(32'h6000, 1'b1, D_55); settle();
        chk_mm("t3_c3", 1'b0, '0, 1'b0, '0);
        cyc(); cyc();
        cyc(); rsp(D_EE); settle();
        chk_rsp("t3_ic_rsp", 1'b1, 1'b0, D_EE);
        cyc(); settle();
        chk_mm("t3_dead", 1'b0, '0, 1'b0, '0);
        chk_busy("t3_dead", 1'b0);
        cyc(); settle();
        chk_mm("t3_store_grant", 1'b1, 32'h6000, 1'b1, D_55);
        cyc(); rsp('0); settle();
        chk_rsp("t3_store_ack", 1'b0, 1'b1, '0);

        // Owner re-requests in the same cycle as its response
        cyc(); ic_req(32'h7000);
        cyc();
        cyc(); settle();
        chk_mm("t5_grant", 1'b1, 32'h7000, 1'b0, '0);
        cyc(); rsp(D_11); ic_req(32'h7100); settle();
        chk_rsp("t5_rsp", 1'b1, 1'b0, D_11);
        cyc(); settle();
        chk_mm("t5_dead", 1'b0, '0, 1'b0, '0);
        chk_busy("t5_dead", 1'b0);
        cyc(); settle();
        chk_mm("t5_regrant", 1'b1, 32'h7100, 1'b0, '0);
        cyc(); rsp(D_22); settle();
        chk_rsp("t5_rsp2", 1'b1, 1'b0, D_22);

        // Spurious response in IDLE is ignored
        cyc(); rsp(D_33); settle();
        chk_rsp("t6_spur", 1'b0, 1'b0, '0);
        chk_busy("t6_spur", 1'b0);
        cyc(); settle();
        chk_mm("t6_spur_next", 1'b0, '0, 1'b0, '0);
        chk_busy("t6_spur_next", 1'b0);

        // Duplicate ic pulse while pending: original address is issued, no extra grant
        cyc(); ic_req(32'h8000);
        cyc(); ic_req(32'h8800); settle();
        chk_mm("t6_dup_c1", 1'b0, '0, 1'b0, '0);
        cyc(); settle();
        chk_mm("t6_dup_grant", 1'b1, 32'h8000, 1'b0, '0);
        cyc(); rsp(D_44); settle();
        chk_rsp("t6_dup_rsp", 1'b1, 1'b0, D_44);
        cyc(); cyc(); settle();
        chk_mm("t6_no_extra", 1'b0, '0, 1'b0, '0);
        chk_busy("t6_no_extra", 1'b0);

        // Reset in WAIT_RSP drops the transaction
        cyc(); ic_req(32'h9000);
        cyc();
        cyc(); settle();
        chk_mm("t4_grant", 1'b1, 32'h9000, 1'b0, '0);
        cyc(); rst = 1'b1; settle();
        chk_busy("t4_pre_rst", 1'b1);
        cyc(); rst = 1'b0; settle();
        chk_busy("t4_post_rst", 1'b0);
        check("t4_post_rst_mm_valid", LW'(mm_bus.req_valid), '0);
        check("t4_post_rst_mm_addr", LW'(mm_bus.req_addr), '0);
        cyc(); rsp(D_66); settle();
        chk_rsp("t4_late_rsp", 1'b0, 1'b0, '0);
        chk_busy("t4_late_rsp", 1'b0);
        cyc(); ic_req(32'hA000);
        cyc();
        cyc(); settle();
        chk_mm("t4_new_grant", 1'b1, 32'hA000, 1'b0, '0);
        cyc(); rsp(D_77); settle();
        chk_rsp("t4_new_rsp", 1'b1, 1'b0, D_77);
        cyc(); settle();
        chk_busy("t4_end", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
